// File: rtl/riscv_mem_pkg.sv
// Shared memory-port types: widths, arbiter state encoding and the latched request payload.
package riscv_mem_pkg;

  localparam int unsigned ADDR_W = 48;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-stage and external memory port signals around mem_port_arbiter.
interface mem_port_arbiter_if;
  import riscv_mem_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  // Arbiter side
  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_err
  );

  // Requesters and memory side
  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the external memory port between fetch and the data stage, one access in flight.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts an access after TIMEOUT cycles.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic               clk,
  input  logic               n_reset,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state, state_nxt;
  mem_req_t          payload;
  logic [SC_W-1:0]   starve_cnt;
  logic              if_gnt_c, dm_gnt_c;
  logic              busy, ack_c, timeout_c, done_c, err_q;
  logic              if_rvalid_q, dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  assign busy   = (state != IDLE);
  assign ack_c  = busy & bus.mem_ack;
  assign done_c = ack_c | timeout_c;

  always_comb begin
    if_gnt_c  = 1'b0;
    dm_gnt_c  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.if_req && (!bus.dm_req || starve_cnt == SC_W'(STARVE_LIMIT))) begin
          if_gnt_c  = 1'b1;
          state_nxt = BUSY_IF;
        end else if (bus.dm_req) begin
          dm_gnt_c  = 1'b1;
          state_nxt = BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: if (done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      state       <= IDLE;
      payload     <= '0;
      starve_cnt  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state       <= state_nxt;
      if_rvalid_q <= done_c && (state == BUSY_IF);
      dm_rvalid_q <= done_c && (state == BUSY_DM);
      if (if_gnt_c)
        payload <= '{we: 1'b0, addr: bus.if_addr, wdata: '0, be: '1};
      else if (dm_gnt_c)
        payload <= '{we: bus.dm_we, addr: bus.dm_addr, wdata: bus.dm_wdata, be: bus.dm_be};
      // An aborted access returns zero data; stores always return zero.
      if (done_c && state == BUSY_IF)
        if_rdata_q <= ack_c ? bus.mem_rdata : '0;
      if (done_c && state == BUSY_DM)
        dm_rdata_q <= (ack_c && !payload.we) ? bus.mem_rdata : '0;
      if (state == IDLE) begin
        if (if_gnt_c || !bus.if_req)
          starve_cnt <= '0;
        else if (dm_gnt_c && starve_cnt != SC_W'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timeout_c = busy & ~bus.mem_ack & (wd_cnt == WD_W'(TIMEOUT - 1));

  // Grants only happen from IDLE, so clearing while idle covers every grant.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout_c;
      if (!busy)
        wd_cnt <= '0;
      else if (!bus.mem_ack)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
  assign timeout_c      = 1'b0;
  assign err_q          = 1'b0;
`endif

  // Grants are combinational, so they are masked while reset is asserted.
  assign bus.if_gnt    = if_gnt_c & ~n_reset;
  assign bus.dm_gnt    = dm_gnt_c & ~n_reset;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy & payload.we;
  assign bus.mem_addr  = busy ? payload.addr  : '0;
  assign bus.mem_wdata = busy ? payload.wdata : '0;
  assign bus.mem_be    = busy ? payload.be    : '0;
  assign bus.mem_err   = err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch (stage 1) and the data-memory stage (stage 4), with one transaction in flight at a time.
- Latches the winning requester's payload and drives it on the port until the memory acknowledges.
- Returns read data and completion to the owning requester.
- Data accesses normally win; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 48, address width (matches pipeline mem_addr).
- DATA_W, 64, data width.
- STARVE_LIMIT, 4, consecutive data grants while fetch is waiting before fetch is forced to win.
- TIMEOUT, 255, cycles to wait for mem_ack before aborting (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- n_reset  in  1  reset; asynchronous, active-high (asserted = 1).
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch payload latched.
- if_rvalid  out  1  one-cycle pulse: fetch data returned.
- if_rdata  out  DATA_W  fetch read data.
- dm_req  in  1  data request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_be  in  DATA_W/8  byte enables.
- dm_gnt  out  1  one-cycle pulse: data payload latched.
- dm_rvalid  out  1  one-cycle pulse: load data or store completion.
- dm_rdata  out  DATA_W  load data; 0 for stores.
- mem_req  out  1  port request, held until ack.
- mem_we  out  1  port write enable.
- mem_addr  out  ADDR_W  port address.
- mem_wdata  out  DATA_W  port write data.
- mem_be  out  DATA_W/8  port byte enables; all-ones for fetch.
- mem_ack  in  1  memory completion; mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  memory read data.
- mem_err  out  1  timeout pulse (optional feature; tied 0 otherwise).

Behaviour:
- Reset: state IDLE, starve_cnt 0. Every output is 0.
- Reset mid-transaction drops mem_req immediately and discards the outstanding access. Requesters must reissue.
- States:
  - IDLE: arbitrate.
  - BUSY_IF: fetch owns the port.
  - BUSY_DM: data owns the port.
- Arbitration in IDLE:
  - Both requesting: dm wins unless starve_cnt == STARVE_LIMIT, in which case if wins.
  - Single requester wins.
  - No request: stay IDLE.
- Grant: the winner's gnt pulses in the arbitration cycle. The payload is registered and mem_* are driven from the next cycle. State becomes BUSY_IF or BUSY_DM.
- Requester rule: hold req and payload stable until gnt; req may drop after gnt. A req dropped before gnt is legal and results in no transaction.
- BUSY_x: mem_req = 1 with stable payload until mem_ack.
  - On mem_ack: mem_rdata is registered; next cycle x_rvalid = 1 with x_rdata (dm_rdata = 0 if store). mem_req deasserts and state returns to IDLE in that same next cycle.
  - Earliest new grant is in the IDLE cycle. Minimum request-to-rvalid latency is 3 cycles with immediate ack.
- mem_ack while mem_req = 0 is ignored.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a dm grant while if_req = 1.
  - Clears on an if grant or when if_req = 0 in IDLE.
- x_rdata holds its last value between pulses; only rvalid qualifies it.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With it defined:
  - A watchdog counts BUSY cycles without mem_ack.
  - When the count reaches TIMEOUT: drop mem_req, pulse mem_err and the owner's rvalid with rdata = 0, return to IDLE.
  - The counter clears on every grant.
- Without it: no counter, mem_err tied 0, waits indefinitely.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - ADDR_W and DATA_W constants.
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_DM}.
  - mem_req_t struct {we, addr, wdata, be}, used for the latched payload and reusable by stage 4.
- No sub-module; the FSM, starvation counter and watchdog fit in one module.

Test Plan:
- Single fetch: if_req with if_addr = 0x1000, ack 2 cycles after mem_req → mem_addr = 0x1000, mem_be = 0xFF, mem_we = 0; if_rvalid one cycle after ack with if_rdata = mem_rdata = 0xDEADBEEF_00000013.
- Store: dm_we = 1, dm_addr = 0x2008, dm_wdata = 0x55, dm_be = 0x01 → port carries identical payload; dm_rvalid pulses with dm_rdata = 0; if_rvalid stays 0.
- Contention: if_req and dm_req held high continuously with immediate ack → grant order dm, dm, dm, dm, if, dm… (STARVE_LIMIT = 4).
- Reset mid-access: n_reset = 1 during BUSY_DM → mem_req and every other output 0 in the same cycle; after release, no rvalid is generated for the lost access.
- Spurious ack: mem_ack pulsed in IDLE → no rvalid, no state change.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT = 8, no ack → after 8 BUSY cycles mem_err and dm_rvalid pulse, dm_rdata = 0, next pending request is granted.
